// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit arbiter and its shifter.
package serial_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shift register; the MSB is presented on msb.
module piso_shifter #(
    parameter int unsigned WIDTH = serial_pkg::DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    // Load wins over shift so a new word is never corrupted on the load edge.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter for two parallel producers feeding one MSB-first serial shifter.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sout,
    output logic             frame,
    output logic             grant_id,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_id_t          last_q, last_d;
    req_id_t          grant_id_q, grant_id_d;
    req_id_t          grant;
    logic             idle;
    logic             handshake;
    logic             load;
    logic             shift;
    logic             msb;
    logic [WIDTH-1:0] load_data;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign idle       = (state_q == StIdle);
    assign req0_ready = idle && rst && req0_valid && (grant == 1'b0);
    assign req1_ready = idle && rst && req1_valid && (grant == 1'b1);
    assign handshake  = req0_ready || req1_ready;
    assign load_data  = grant ? req1_data : req0_data;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        grant_id_d = grant_id_q;
        load       = 1'b0;
        shift      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    state_d    = StShift;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    last_d     = grant;
                    grant_id_d = grant;
                    load       = 1'b1;
                end
            end
            StShift: begin
                shift = 1'b1;
                // Exit at zero so the counter never underflows.
                if (cnt_q == '0) begin
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            grant_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            grant_id_q <= grant_id_d;
        end
    end

    piso_shifter #(
        .WIDTH (WIDTH)
    ) u_piso_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (load_data),
        .msb   (msb)
    );

    assign sout     = (state_q == StShift) && msb;
    assign frame    = (state_q == StShift);
    assign busy     = (state_q != StIdle);
    assign grant_id = grant_id_q;

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Two-requester arbiter and sequencer for the serial shift datapath. Accepts parallel words from two independent producers over valid/ready handshakes and grants the shared shift register round-robin. It then shifts the granted word out MSB-first on `sout` with a framing strobe. It sits between parallel producers and any single-bit serial link.

## Interface

**Parameters**
- `WIDTH`, default 8: bits per word; legal range ≥ 2.
- `CNT_W`, default `$clog2(WIDTH)`: bit-counter width; derived, never overridden.

**Ports**
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-low (asserted when 0).
- `req0_valid`  in  1: requester 0 holds a word.
- `req0_data`  in  WIDTH: requester 0 word; must be stable while `req0_valid` is high.
- `req0_ready`  out  1: requester 0 word accepted this cycle when `req0_valid` is also high.
- `req1_valid`  in  1: requester 1 holds a word.
- `req1_data`  in  WIDTH: requester 1 word.
- `req1_ready`  out  1: requester 1 accept strobe.
- `sout`  out  1: serial data, MSB first.
- `frame`  out  1: high exactly during the WIDTH data-bit cycles.
- `grant_id`  out  1: source (0/1) of the word currently shifting; holds last value when idle.
- `busy`  out  1: high in SHIFT and GAP.

## Operation

- **States:** IDLE, SHIFT, GAP.
- **IDLE:**
  - Grant logic is combinational.
  - Only one valid: grant that requester.
  - Both valid: grant the requester ≠ `last` (round-robin pointer).
  - `reqN_ready` = (state == IDLE) && grant == N && rst high. At most one ready is high per cycle.
- **Handshake** (`reqN_valid && reqN_ready` at a rising edge):
  - `shreg <= reqN_data`
  - `cnt <= WIDTH-1`
  - `last <= N`
  - `grant_id <= N`
  - state → SHIFT
- **SHIFT:**
  - `sout = shreg[WIDTH-1]`; `frame = 1`.
  - Each edge: `shreg <= {shreg[WIDTH-2:0], 1'b0}` and `cnt <= cnt-1`.
  - When `cnt == 0` at the edge, state → GAP.
- **GAP:**
  - One cycle; `frame = 0`, `sout = 0`, both readies 0.
  - State → IDLE.
- **Valid without ready:** a requester may raise valid at any time. Valid held without ready is never lost, and data is sampled only at the handshake edge.
- **Dropped valid:** a requester that drops valid before ready forfeits nothing; the pointer moves only on a handshake.
- **Counter:** `cnt` is unsigned and never wraps below 0, because the SHIFT exit happens at 0.

## Timing

- **Reset values** (async, on rst = 0):
  - state = IDLE, `shreg` = 0, `cnt` = 0, `last` = 1 (requester 0 wins the first tie), `grant_id` = 0.
  - Outputs: `sout` = 0, `frame` = 0, `busy` = 0, both readies 0.
- **Reset mid-frame:** the frame aborts immediately (`sout`/`frame` drop asynchronously). No partial resume after release; the first cycle after release is IDLE.
- **Latency:**
  - Handshake at edge T puts the MSB on `sout` in cycle T+1.
  - LSB is on `sout` in cycle T+WIDTH.
  - GAP is cycle T+WIDTH+1.
  - Next handshake is possible no earlier than the edge ending cycle T+WIDTH+2 (IDLE).
- **Throughput:** one word per WIDTH+2 cycles with continuous traffic.
- **Simultaneous valid rise:** arbitration uses `last`. Back-to-back saturation alternates strictly 0,1,0,1.
- **Outputs:** `sout`, `frame`, `busy`, `grant_id` are functions of registers only (no input-to-output paths). The readies depend combinationally on both valids.

## Structure

- **Shared package `serial_pkg`:**
  - state enum (IDLE/SHIFT/GAP, 2-bit encoding)
  - default WIDTH constant
  - requester-id type
- **Sub-module `piso_shifter`:**
  - inputs `clk`, `rst`, `load`, `shift`, `din[WIDTH]`
  - output `msb`
  - owns `shreg`
- **Top:** the arbiter/FSM instantiates one `piso_shifter` and owns `cnt`, `last`, `grant_id` and the state.

## Test plan

All scenarios use WIDTH = 8.

1. **Reset:** hold rst = 0 with both valids high → both readies 0, `sout` = 0, `frame` = 0. Release; next cycle `req0_ready` = 1 (first tie goes to 0).
2. **Single word:** `req0_data` = 8'hA5, valid for one handshake → `sout` = 1,0,1,0,0,1,0,1 in cycles T+1..T+8. `frame` high exactly those 8 cycles, `grant_id` = 0, GAP at T+9.
3. **Round-robin saturation:** both valids held high with data 8'hF0 / 8'h0F → grants alternate 0,1,0,1. Handshakes exactly 10 cycles apart; no ready while busy.
4. **Lone requester:** only `req1` valid repeatedly (8'h81) → every grant goes to 1. The pointer does not block it; `sout` = 1,0,0,0,0,0,0,1 per frame.
5. **Reset mid-frame:** assert rst = 0 during the 4th data bit of 8'hFF → `sout`/`frame` drop to 0 immediately. After release, a pending `req1` (8'h3C) is granted per the reset pointer and shifts fully.
6. **Late valid:** `req1_valid` rises in the GAP cycle while `req0` is idle → `req1_ready` is high in the following IDLE cycle, and `req1` is serviced without loss.
